mt9v034_vid_to_axis: RTL and testbench

MT9V034_VID_TO_AXIS -- requirements
Module: mt9v034_vid_to_axis

---
 rtl/mt9v034_vid_to_axis.sv | 199 +++++++++++++++++++
 tb/tb_mt9v034_vid_to_axis.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mt9v034_vid_to_axis.sv
// MT9V034 deserialized video to AXI4-Stream bridge: frame/line framing, one-pixel
// hold register for end-of-line tagging, and an output FIFO with sticky overflow.
module mt9v034_vid_to_axis #(
  parameter int unsigned VIDEO_BIT_WIDTH = 10,
  parameter int unsigned TDATA_WIDTH     = 16,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic                       pxclk,
  input  logic                       rst,
  input  logic                       receiver_locked,
  input  logic                       pixel_data_valid,
  input  logic [VIDEO_BIT_WIDTH-1:0] vid_data,
  input  logic                       vid_active_video,
  input  logic                       vid_hblank,
  input  logic                       vid_vblank,
  output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       overflow,
  output logic [15:0]                frame_count,
  output logic [11:0]                line_width
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = VIDEO_BIT_WIDTH + 2;
  localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StWaitLock, StWaitVblank, StActive, StDrop} state_e;

  // Assert asynchronously, release on the second pxclk edge.
  logic [1:0] rst_sync_q;
  logic       rst_int;
  always_ff @(posedge pxclk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  state_e                     state_q, state_d;
  logic                       hold_vld_q, hold_vld_d;
  logic [VIDEO_BIT_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                       hold_sof_q, hold_sof_d;
  logic                       sof_pend_q, sof_pend_d;
  logic                       line_seen_q, line_seen_d;
  logic [11:0]                pix_cnt_q, pix_cnt_d;
  logic [11:0]                line_width_q, line_width_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic                       ovf_q, ovf_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                cnt_q, cnt_d;
  logic [EW-1:0]              mem_q [FIFO_DEPTH];

  logic          sample, is_pix, is_vb, push_req, push, pop, fifo_full;
  logic [EW-1:0] push_word, head;

  assign sample        = pixel_data_valid;
  // A word flagged as blanking is never treated as a pixel.
  assign is_pix        = sample & vid_active_video & ~vid_hblank & ~vid_vblank;
  assign is_vb         = sample & vid_vblank;
  assign fifo_full     = (cnt_q == FullCnt);
  assign m_axis_tvalid = (cnt_q != '0);
  assign pop           = m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_d      = state_q;
    hold_vld_d   = hold_vld_q;
    hold_data_d  = hold_data_q;
    hold_sof_d   = hold_sof_q;
    sof_pend_d   = sof_pend_q;
    line_seen_d  = line_seen_q;
    pix_cnt_d    = pix_cnt_q;
    line_width_d = line_width_q;
    frame_cnt_d  = frame_cnt_q;
    ovf_d        = ovf_q;
    push_req     = 1'b0;
    push         = 1'b0;
    push_word    = {hold_sof_q, ~is_pix, hold_data_q};
    if (!receiver_locked) begin
      state_d     = StWaitLock;
      hold_vld_d  = 1'b0;
      sof_pend_d  = 1'b0;
      line_seen_d = 1'b0;
      pix_cnt_d   = '0;
    end else begin
      unique case (state_q)
        StWaitLock: state_d = StWaitVblank;
        StWaitVblank, StDrop: begin
          if (is_vb) begin
            state_d    = StActive;
            sof_pend_d = 1'b1;
          end
        end
        StActive: begin
          push_req = sample & hold_vld_q;
          if (push_req && fifo_full && !pop) begin
            ovf_d       = 1'b1;
            hold_vld_d  = 1'b0;
            line_seen_d = 1'b0;
            pix_cnt_d   = '0;
            state_d     = StDrop;
          end else begin
            push = push_req;
            if (push_req && !is_pix) begin
              line_width_d = pix_cnt_q;
              pix_cnt_d    = '0;
              line_seen_d  = 1'b1;
              hold_vld_d   = 1'b0;
            end
            if (is_pix) begin
              hold_vld_d  = 1'b1;
              hold_data_d = vid_data;
              hold_sof_d  = sof_pend_q;
              sof_pend_d  = 1'b0;
              if (pix_cnt_q != 12'hfff) pix_cnt_d = pix_cnt_q + 12'd1;
            end
            if (is_vb) begin
              sof_pend_d = 1'b1;
              if (line_seen_d) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                line_seen_d = 1'b0;
              end
            end
          end
        end
        default: state_d = StWaitLock;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge pxclk or posedge rst_int) begin
    if (rst_int) begin
      state_q      <= StWaitLock;
      hold_vld_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_sof_q   <= 1'b0;
      sof_pend_q   <= 1'b0;
      line_seen_q  <= 1'b0;
      pix_cnt_q    <= '0;
      line_width_q <= '0;
      frame_cnt_q  <= '0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
      hold_sof_q   <= hold_sof_d;
      sof_pend_q   <= sof_pend_d;
      line_seen_q  <= line_seen_d;
      pix_cnt_q    <= pix_cnt_d;
      line_width_q <= line_width_d;
      frame_cnt_q  <= frame_cnt_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Storage needs no reset: the output is gated by tvalid.
  always_ff @(posedge pxclk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tuser = 1'b0;
    m_axis_tlast = 1'b0;
    if (m_axis_tvalid) begin
      m_axis_tdata[VIDEO_BIT_WIDTH-1:0] = head[VIDEO_BIT_WIDTH-1:0];
      m_axis_tuser                      = head[EW-1];
      m_axis_tlast                      = head[EW-2];
    end
  end

  assign overflow    = ovf_q;
  assign frame_count = frame_cnt_q;
  assign line_width  = line_width_q;

endmodule

// File: tb/tb_mt9v034_vid_to_axis.sv
// Directed bench for mt9v034_vid_to_axis: expected beats queued as pixels are driven,
// popped and checked as the AXI stream accepts them.
module tb_mt9v034_vid_to_axis;

  logic        pxclk = 1'b0;
  logic        rst = 1'b0;
  logic        receiver_locked = 1'b0;
  logic        pixel_data_valid = 1'b0;
  logic [9:0]  vid_data = '0;
  logic        vid_active_video = 1'b0;
  logic        vid_hblank = 1'b0;
  logic        vid_vblank = 1'b0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        overflow;
  logic [15:0] frame_count;
  logic [11:0] line_width;

  mt9v034_vid_to_axis #(
    .VIDEO_BIT_WIDTH(10),
    .TDATA_WIDTH    (16),
    .FIFO_DEPTH     (16)
  ) dut (
    .pxclk           (pxclk),
    .rst             (rst),
    .receiver_locked (receiver_locked),
    .pixel_data_valid(pixel_data_valid),
    .vid_data        (vid_data),
    .vid_active_video(vid_active_video),
    .vid_hblank      (vid_hblank),
    .vid_vblank      (vid_vblank),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tuser    (m_axis_tuser),
    .m_axis_tlast    (m_axis_tlast),
    .overflow        (overflow),
    .frame_count     (frame_count),
    .line_width      (line_width)
  );

  always #5 pxclk = ~pxclk;

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [15:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          toggle = 1'b0;
  logic [17:0] prev_beat;
  bit          prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beats are accepted on the next rising edge when tvalid&tready hold at the falling edge.
  always @(negedge pxclk) begin
    beat_t e;
    bit    avail;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_axis_tvalid)
        chk("stall_stable", {14'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {14'd0, prev_beat});
      if (m_axis_tvalid && m_axis_tready) begin
        avail = (exp_q.size() != 0);
        chk("beat_expected", 32'(avail), 32'd1);
        if (avail) begin
          e = exp_q.pop_front();
          chk("tdata", 32'(m_axis_tdata), 32'(e.data));
          chk("tuser", 32'(m_axis_tuser), 32'(e.tuser));
          chk("tlast", 32'(m_axis_tlast), 32'(e.tlast));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  task automatic smp(input bit pdv, input logic [9:0] d, input bit av, input bit hb, input bit vb);
    @(posedge pxclk);
    #1;
    pixel_data_valid = pdv;
    vid_data         = d;
    vid_active_video = av;
    vid_hblank       = hb;
    vid_vblank       = vb;
  endtask

  task automatic idle(input int n);
    repeat (n) smp(1'b0, 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic gap();
    if (toggle) idle(1);
  endtask

  task automatic pix(input logic [9:0] d);
    gap();
    smp(1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic hblank();
    gap();
    smp(1'b1, 10'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic vblank();
    gap();
    smp(1'b1, 10'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic line(input int n, input int base, input bit sof, input bit expect_out);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      pix(10'(base + i));
      if (expect_out) begin
        b.tuser = sof && (i == 0);
        b.tlast = (i == n - 1);
        b.data  = 16'(base + i);
        exp_q.push_back(b);
      end
    end
    hblank();
  endtask

  task automatic frame(input int lines, input int ppl, input int base);
    for (int l = 0; l < lines; l++) line(ppl, base + l * ppl, l == 0, 1'b1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 2000) begin
      @(negedge pxclk);
      t++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    idle(4);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge pxclk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_line_width", 32'(line_width), 32'd0);
    rst = 1'b0;

    // Basic frame: 3 lines x 4 pixels.
    receiver_locked = 1'b1;
    idle(4);
    m_axis_tready = 1'b1;
    vblank();
    frame(3, 4, 1);
    drain();
    chk("basic_line_width", 32'(line_width), 32'd4);
    chk("basic_frame_count", 32'(frame_count), 32'd0);
    vblank();
    idle(1);
    chk("frame_count_1", 32'(frame_count), 32'd1);

    // Second frame carries tuser again.
    frame(3, 4, 1);
    drain();
    vblank();
    idle(1);
    chk("frame_count_2", 32'(frame_count), 32'd2);

    // Qualifier toggling with garbage in between.
    toggle = 1'b1;
    frame(3, 4, 1);
    drain();
    chk("toggle_line_width", 32'(line_width), 32'd4);
    vblank();
    idle(1);
    chk("frame_count_3", 32'(frame_count), 32'd3);
    toggle = 1'b0;

    // Lock loss mid-line after pixel 2: pixel 1 goes out, pixel 2 is lost.
    begin
      beat_t b;
      b.tuser = 1'b1;
      b.tlast = 1'b0;
      b.data  = 16'h021;
      exp_q.push_back(b);
    end
    pix(10'h021);
    pix(10'h022);
    @(posedge pxclk);
    #1;
    receiver_locked  = 1'b0;
    pixel_data_valid = 1'b0;
    idle(3);
    pix(10'h030);
    pix(10'h031);
    hblank();
    @(posedge pxclk);
    #1 receiver_locked = 1'b1;
    idle(2);
    pix(10'h040);
    hblank();
    vblank();
    frame(3, 4, 1);
    drain();
    vblank();
    idle(1);
    chk("relock_frame_count", 32'(frame_count), 32'd4);

    // Backpressure: 16-pixel line fills the FIFO, next write overflows.
    m_axis_tready = 1'b0;
    vblank();
    line(16, 1, 1'b1, 1'b1);
    idle(2);
    chk("full_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("full_head", 32'(m_axis_tdata), 32'h1);
    chk("full_overflow", 32'(overflow), 32'd0);
    chk("full_line_width", 32'(line_width), 32'd16);
    vblank();
    pix(10'h050);
    pix(10'h051);
    idle(1);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head_kept", 32'(m_axis_tdata), 32'h1);
    m_axis_tready = 1'b1;
    pix(10'h060);
    pix(10'h061);
    hblank();
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    vblank();
    line(2, 'h070, 1'b1, 1'b1);
    drain();

    // Asynchronous reset mid-line with data queued.
    m_axis_tready = 1'b0;
    vblank();
    pix(10'h001);
    pix(10'h002);
    pix(10'h003);
    idle(2);
    chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    @(posedge pxclk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
    chk("mid_rst_line_width", 32'(line_width), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge pxclk);
    #1 rst = 1'b0;
    m_axis_tready = 1'b1;
    idle(4);
    vblank();
    line(4, 'h100, 1'b1, 1'b1);
    drain();
    chk("post_rst_line_width", 32'(line_width), 32'd4);
    chk("post_rst_overflow", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
